// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue sequencer: opcode mnemonics, FSM and
// branch-condition encodings, instruction field positions and decode payload.
package alu_issue_ctrl_pkg;

    localparam int unsigned NREG_BITS = 3;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned OPC_W     = 4;
    localparam int unsigned CF_W      = 3;
    localparam int unsigned COND_W    = 2;
    localparam int unsigned INST_W    = OPC_W + CF_W + COND_W;

    // Instruction word: [8:5] opcode, [4:2] Rd / ControlFlags, [1:0] Rm / condition
    localparam int unsigned OPC_MSB = 8;
    localparam int unsigned OPC_LSB = 5;
    localparam int unsigned RD_MSB  = 4;
    localparam int unsigned RD_LSB  = 2;
    localparam int unsigned RM_MSB  = 1;
    localparam int unsigned RM_LSB  = 0;

    localparam logic [NREG_BITS-1:0] RC_DEST_DFLT = 3'd0;

    // ALU opcodes; 4'd15 has no mnemonic and is treated as illegal
    typedef enum logic [OPC_W-1:0] {
        kRC_ADD      = 4'd0,
        kRC_SUB      = 4'd1,
        kRC_LSL      = 4'd2,
        kRC_LSR      = 4'd3,
        kRC_TRANSFER = 4'd4,
        kRC_CUSTOM   = 4'd5,
        kREG_COPY    = 4'd6,
        kADD         = 4'd7,
        kSUB         = 4'd8,
        kXOR         = 4'd9,
        kAND         = 4'd10,
        kLSL         = 4'd11,
        kLSR         = 4'd12,
        kCMP         = 4'd13,
        kBRANCH      = 4'd14
    } op_mne;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } ctrl_state_t;

    typedef enum logic [COND_W-1:0] {
        BR_AL = 2'd0,
        BR_Z  = 2'd1,
        BR_N  = 2'd2,
        BR_NZ = 2'd3
    } br_cond_t;

    typedef struct packed {
        logic writes_reg;
        logic writes_flags;
        logic is_branch;
        logic is_custom;
        logic is_illegal;
    } dec_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake, register-file, ALU and writeback/status bundle.
// master: the issue controller. slave: fetch + register file + ALU side.
interface alu_issue_ctrl_if;
    import alu_issue_ctrl_pkg::*;

    logic                 inst_valid;
    logic [INST_W-1:0]    inst;
    logic                 inst_ready;
    logic [NREG_BITS-1:0] ra_addr;
    logic [NREG_BITS-1:0] rb_addr;
    logic [DATA_W-1:0]    ra_data;
    logic [DATA_W-1:0]    rb_data;
    logic [OPC_W-1:0]     alu_op;
    logic [CF_W-1:0]      alu_cf;
    logic [DATA_W-1:0]    alu_a;
    logic [DATA_W-1:0]    alu_b;
    logic [DATA_W-1:0]    alu_out;
    logic                 alu_zero;
    logic                 alu_neg;
    logic                 wr_en;
    logic [NREG_BITS-1:0] wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic                 flag_z;
    logic                 flag_n;
    logic                 branch_taken;
    logic                 illegal;
    logic                 busy;

    modport master (
        input  inst_valid, inst, ra_data, rb_data, alu_out, alu_zero, alu_neg,
        output inst_ready, ra_addr, rb_addr, alu_op, alu_cf, alu_a, alu_b,
               wr_en, wr_addr, wr_data, flag_z, flag_n, branch_taken, illegal, busy
    );

    modport slave (
        output inst_valid, inst, ra_data, rb_data, alu_out, alu_zero, alu_neg,
        input  inst_ready, ra_addr, rb_addr, alu_op, alu_cf, alu_a, alu_b,
               wr_en, wr_addr, wr_data, flag_z, flag_n, branch_taken, illegal, busy
    );

endinterface

// File: rtl/alu_issue_decode.sv
// Opcode classifier for the issue sequencer.
// Ports: opcode (in, 4b) -> dec_c (out, combinational decode flags).
module alu_issue_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output dec_t             dec_c
);

    always_comb begin
        dec_c = '0;
        case (opcode)
            kRC_ADD, kRC_SUB, kRC_LSL, kRC_LSR, kRC_TRANSFER, kREG_COPY,
            kADD, kSUB, kXOR, kAND, kLSL, kLSR: dec_c.writes_reg = 1'b1;
            kRC_CUSTOM: begin
                dec_c.writes_reg = 1'b1;
                dec_c.is_custom  = 1'b1;
            end
            kCMP:    dec_c.writes_flags = 1'b1;
            kBRANCH: dec_c.is_branch    = 1'b1;
            default: dec_c.is_illegal   = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue sequencer driving a combinational ALU: accepts one
// instruction per handshake, reads operands, captures the ALU result and
// performs writeback, flag update or branch resolution.
// Ports: Clk, Reset (async, active-high); bus (alu_issue_ctrl_if.master)
// carrying instruction handshake, register-file read/write, ALU operands and
// results, architectural flags and status pulses.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter logic [NREG_BITS-1:0] RC_DEST = RC_DEST_DFLT
) (
    input  logic               Clk,
    input  logic               Reset,
    alu_issue_ctrl_if.master   bus
);

    ctrl_state_t          state_q, state_nxt;
    logic [INST_W-1:0]    ir_q;
    logic [DATA_W-1:0]    opa_q, opb_q;
    logic [OPC_W-1:0]     alu_op_q;
    logic [CF_W-1:0]      alu_cf_q;
    logic                 wr_en_q;
    logic [NREG_BITS-1:0] wr_addr_q;
    logic [DATA_W-1:0]    wr_data_q;
    logic                 flag_z_q, flag_n_q;
    logic                 branch_q, illegal_q;
    logic                 ready_q, busy_q;
    logic                 accept_c;
    logic                 cond_c;
    dec_t                 dec_c;

    alu_issue_decode u_decode (
        .opcode (ir_q[OPC_MSB:OPC_LSB]),
        .dec_c  (dec_c)
    );

    assign accept_c = (state_q == IDLE) && bus.inst_valid;

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_nxt = DECODE;
            DECODE:  state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Branch condition, evaluated on the flags held before writeback
    always_comb begin
        cond_c = 1'b0;
        case (br_cond_t'(ir_q[RM_MSB:RM_LSB]))
            BR_AL:   cond_c = 1'b1;
            BR_Z:    cond_c = flag_z_q;
            BR_N:    cond_c = flag_n_q;
            BR_NZ:   cond_c = !flag_z_q;
            default: cond_c = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_nxt;
    end

    // Datapath; WB-visible outputs are loaded on the EXEC->WB edge so they
    // are valid for exactly the WB cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ir_q      <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            alu_op_q  <= '0;
            alu_cf_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            flag_z_q  <= 1'b0;
            flag_n_q  <= 1'b0;
            branch_q  <= 1'b0;
            illegal_q <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            ready_q   <= (state_nxt == IDLE);
            busy_q    <= (state_nxt != IDLE);
            wr_en_q   <= 1'b0;
            branch_q  <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                IDLE: if (accept_c) ir_q <= bus.inst;
                DECODE: begin
                    opa_q    <= bus.ra_data;
                    opb_q    <= bus.rb_data;
                    alu_op_q <= ir_q[OPC_MSB:OPC_LSB];
                    alu_cf_q <= ir_q[RD_MSB:RD_LSB];
                end
                EXEC: begin
                    if (dec_c.writes_reg) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= dec_c.is_custom ? RC_DEST : ir_q[RD_MSB:RD_LSB];
                        wr_data_q <= bus.alu_out;
                    end
                    if (dec_c.writes_flags) begin
                        flag_z_q <= bus.alu_zero;
                        flag_n_q <= bus.alu_neg;
                    end
                    if (dec_c.is_branch)  branch_q  <= cond_c;
                    if (dec_c.is_illegal) illegal_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.inst_ready   = ready_q;
    assign bus.busy         = busy_q;
    assign bus.ra_addr      = ir_q[RD_MSB:RD_LSB];
    assign bus.rb_addr      = {1'b0, ir_q[RM_MSB:RM_LSB]};
    assign bus.alu_op       = alu_op_q;
    assign bus.alu_cf       = alu_cf_q;
    assign bus.alu_a        = opa_q;
    assign bus.alu_b        = opb_q;
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.flag_z       = flag_z_q;
    assign bus.flag_n       = flag_n_q;
    assign bus.branch_taken = branch_q;
    assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a behavioural register file and ALU
// sit on the slave side; expected results come from an instruction-level model.
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    logic Clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] rf [8];
    logic       m_fz = 1'b0;
    logic       m_fn = 1'b0;

    always #5 Clk = ~Clk;

    alu_issue_ctrl_if bus();

    alu_issue_ctrl #(.RC_DEST(3'd0)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // Behavioural ALU: RC ops use ControlFlags as the constant operand
    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [2:0] cf,
                                         input logic [7:0] a, input logic [7:0] b);
        logic [7:0] k;
        k = {5'd0, cf};
        case (op)
            4'd0:  return a + k;
            4'd1:  return a - k;
            4'd2:  return a << cf;
            4'd3:  return a >> cf;
            4'd4:  return k;
            4'd5: begin
                case (cf)
                    3'd0: return 8'h00;
                    3'd1: return 8'h01;
                    3'd2: return 8'h3C;
                    3'd3: return 8'hFF;
                    3'd4: return 8'h7F;
                    3'd5: return 8'h55;
                    3'd6: return 8'h80;
                    default: return 8'hC3;
                endcase
            end
            4'd6:  return b;
            4'd7:  return a + b;
            4'd8:  return a - b;
            4'd9:  return a ^ b;
            4'd10: return a & b;
            4'd11: return a << b[2:0];
            4'd12: return a >> b[2:0];
            4'd13: return a - b;
            default: return 8'h00;
        endcase
    endfunction

    assign bus.ra_data  = rf[bus.ra_addr];
    assign bus.rb_data  = rf[bus.rb_addr];
    assign bus.alu_out  = alu_f(bus.alu_op, bus.alu_cf, bus.alu_a, bus.alu_b);
    assign bus.alu_zero = (bus.alu_out == 8'h00);
    assign bus.alu_neg  = bus.alu_out[7];

    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic       fz, fn, br, ill;
    } exp_t;

    typedef struct {
        logic [4:1] rdy, bsy, we, br, ill;
        logic [2:0] wa;
        logic [7:0] wd;
        logic       fz, fn;
    } obs_t;

    // Instruction-level reference: what one instruction does to regs and flags
    function automatic exp_t model(input logic [8:0] w);
        exp_t       e;
        logic [3:0] op;
        logic [2:0] rd;
        logic [1:0] rm;
        logic [7:0] r;
        op = w[8:5];
        rd = w[4:2];
        rm = w[1:0];
        r  = alu_f(op, rd, rf[rd], rf[{1'b0, rm}]);
        e.we = 1'b0; e.wa = 3'd0; e.wd = 8'h00;
        e.fz = m_fz; e.fn = m_fn; e.br = 1'b0; e.ill = 1'b0;
        if (op == 4'd15) e.ill = 1'b1;
        else if (op == 4'd13) begin
            e.fz = (r == 8'h00);
            e.fn = r[7];
        end else if (op == 4'd14) begin
            case (rm)
                2'd0: e.br = 1'b1;
                2'd1: e.br = m_fz;
                2'd2: e.br = m_fn;
                default: e.br = !m_fz;
            endcase
        end else begin
            e.we = 1'b1;
            e.wa = (op == 4'd5) ? 3'd0 : rd;
            e.wd = r;
        end
        return e;
    endfunction

    // Issue one word and record per-cycle observations (cycle 1..4 after accept).
    // With junk set, inst_valid stays high with other words while busy.
    task automatic exec_inst(input logic [8:0] w, input bit junk, output obs_t o);
        int n;
        o.rdy = '0; o.bsy = '0; o.we = '0; o.br = '0; o.ill = '0;
        o.wa = '0; o.wd = '0; o.fz = 1'b0; o.fn = 1'b0;
        n = 0;
        while (bus.inst_ready !== 1'b1 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout inst_ready=%b required=1", bus.inst_ready);
        end
        bus.inst       = w;
        bus.inst_valid = 1'b1;
        @(posedge Clk);
        #1;
        if (junk) bus.inst = 9'($urandom);
        else      bus.inst_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge Clk);
            o.rdy[c] = bus.inst_ready;
            o.bsy[c] = bus.busy;
            o.we[c]  = bus.wr_en;
            o.br[c]  = bus.branch_taken;
            o.ill[c] = bus.illegal;
            if (bus.wr_en === 1'b1) begin
                o.wa = bus.wr_addr;
                o.wd = bus.wr_data;
                rf[bus.wr_addr] = bus.wr_data;
            end
            if (c == 4) begin
                o.fz = bus.flag_z;
                o.fn = bus.flag_n;
            end
            if (junk && c < 4) begin
                @(posedge Clk);
                #1;
                if (c < 3) bus.inst = 9'($urandom);
                else       bus.inst_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        logic [40:0] v;
        Reset = 1'b1;
        bus.inst_valid = 1'b0;
        bus.inst = '0;
        for (int i = 0; i < 8; i++) rf[i] = 8'h00;
        repeat (3) @(negedge Clk);
        v = {bus.wr_en, bus.wr_addr, bus.wr_data, bus.flag_z, bus.flag_n, bus.branch_taken,
             bus.illegal, bus.busy, bus.alu_op, bus.alu_cf, bus.alu_a, bus.alu_b, bus.inst_ready};
        checks++;
        if (v !== {40'h0, 1'b1}) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=%h", v, {40'h0, 1'b1});
        end
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if ({bus.inst_ready, bus.busy} !== 2'b10) begin
            failures++;
            $display("FAIL reset_idle ready_busy=%b required=10", {bus.inst_ready, bus.busy});
        end
        m_fz = 1'b0;
        m_fn = 1'b0;
    endtask

    task automatic test_add();
        obs_t o;
        rf[2] = 8'h05;
        rf[1] = 8'h03;
        exec_inst({4'd7, 3'd2, 2'd1}, 1'b0, o);
        checks++;
        if (o.we !== 4'b0100) begin failures++; $display("FAIL add_wr_en cycles=%b required=0100", o.we); end
        checks++;
        if ({o.wa, o.wd} !== {3'd2, 8'h08}) begin
            failures++; $display("FAIL add_write addr/data=%h/%h required=2/08", o.wa, o.wd);
        end
        checks++;
        if ({o.fz, o.fn} !== 2'b00) begin failures++; $display("FAIL add_flags got=%b required=00", {o.fz, o.fn}); end
        checks++;
        if ({o.rdy, o.bsy} !== {4'b1000, 4'b0111}) begin
            failures++; $display("FAIL add_ready_busy got=%b/%b required=1000/0111", o.rdy, o.bsy);
        end
    endtask

    task automatic test_cmp_branch();
        obs_t o;
        rf[3] = 8'h10;
        rf[2] = 8'h10;
        exec_inst({4'd13, 3'd3, 2'd2}, 1'b0, o);
        checks++;
        if ({o.we, o.fz, o.fn} !== {4'b0000, 2'b10}) begin
            failures++; $display("FAIL cmp_equal we=%b z/n=%b required=0000/10", o.we, {o.fz, o.fn});
        end
        m_fz = 1'b1;
        m_fn = 1'b0;
        exec_inst({4'd14, 3'd0, 2'b01}, 1'b0, o);
        checks++;
        if ({o.br, o.we} !== {4'b0100, 4'b0000}) begin
            failures++; $display("FAIL branch_z br=%b we=%b required=0100/0000", o.br, o.we);
        end
        exec_inst({4'd14, 3'd0, 2'b11}, 1'b0, o);
        checks++;
        if ({o.br, o.fz, o.fn} !== {4'b0000, 2'b10}) begin
            failures++; $display("FAIL branch_nz br=%b z/n=%b required=0000/10", o.br, {o.fz, o.fn});
        end
    endtask

    task automatic test_custom();
        obs_t o;
        exec_inst({4'd5, 3'b110, 2'd1}, 1'b0, o);
        checks++;
        if ({o.we, o.wa, o.wd} !== {4'b0100, 3'd0, 8'h80}) begin
            failures++; $display("FAIL custom we=%b addr=%h data=%h required=0100/0/80", o.we, o.wa, o.wd);
        end
    endtask

    task automatic test_sub_wrap();
        obs_t o;
        rf[1] = 8'h01;
        rf[0] = 8'h02;
        exec_inst({4'd8, 3'd1, 2'd0}, 1'b0, o);
        checks++;
        if ({o.we, o.wa, o.wd} !== {4'b0100, 3'd1, 8'hFF}) begin
            failures++; $display("FAIL sub_wrap we=%b addr=%h data=%h required=0100/1/ff", o.we, o.wa, o.wd);
        end
        exec_inst({4'd13, 3'd1, 2'd0}, 1'b0, o);
        checks++;
        if ({o.fz, o.fn} !== 2'b01) begin failures++; $display("FAIL cmp_neg z/n=%b required=01", {o.fz, o.fn}); end
        m_fz = 1'b0;
        m_fn = 1'b1;
    endtask

    task automatic test_back_to_back();
        obs_t       o;
        logic [7:0] expd;
        rf[4] = 8'($urandom);
        rf[3] = 8'($urandom);
        expd  = rf[4] ^ rf[3];
        exec_inst({4'd9, 3'd4, 2'd3}, 1'b1, o);
        checks++;
        if ({o.rdy, o.we} !== {4'b1000, 4'b0100}) begin
            failures++; $display("FAIL busy_ignore ready=%b we=%b required=1000/0100", o.rdy, o.we);
        end
        checks++;
        if ({o.wa, o.wd} !== {3'd4, expd}) begin
            failures++; $display("FAIL busy_first_word addr/data=%h/%h required=4/%h", o.wa, o.wd, expd);
        end
        @(negedge Clk);
        checks++;
        if ({bus.inst_ready, bus.busy, bus.wr_en} !== 3'b100) begin
            failures++; $display("FAIL busy_no_second ready/busy/we=%b required=100", {bus.inst_ready, bus.busy, bus.wr_en});
        end
    endtask

    task automatic test_reset_mid();
        obs_t        o;
        logic [40:0] v;
        int          seen;
        rf[2] = 8'h05;
        rf[1] = 8'h03;
        bus.inst = {4'd7, 3'd2, 2'd1};
        bus.inst_valid = 1'b1;
        @(posedge Clk);
        #1;
        bus.inst_valid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        v = {bus.wr_en, bus.wr_addr, bus.wr_data, bus.flag_z, bus.flag_n, bus.branch_taken,
             bus.illegal, bus.busy, bus.alu_op, bus.alu_cf, bus.alu_a, bus.alu_b, bus.inst_ready};
        checks++;
        if (v !== {40'h0, 1'b1}) begin
            failures++; $display("FAIL reset_mid_outputs got=%h required=%h", v, {40'h0, 1'b1});
        end
        @(negedge Clk);
        Reset = 1'b0;
        m_fz = 1'b0;
        m_fn = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge Clk);
            if (bus.wr_en !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL reset_mid_no_write wr_en_cycles=%0d required=0", seen); end
        exec_inst({4'd15, 5'($urandom)}, 1'b0, o);
        checks++;
        if ({o.ill, o.we, o.br} !== {4'b0100, 8'h00}) begin
            failures++; $display("FAIL illegal ill=%b we=%b br=%b required=0100/0000/0000", o.ill, o.we, o.br);
        end
        checks++;
        if ({o.fz, o.fn} !== 2'b00) begin failures++; $display("FAIL illegal_flags z/n=%b required=00", {o.fz, o.fn}); end
    endtask

    task automatic test_random();
        obs_t       o;
        exp_t       e;
        logic [8:0] w;
        for (int i = 0; i < 8; i++) rf[i] = 8'($urandom);
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 3) == 0) rf[$urandom_range(0, 7)] = rf[$urandom_range(0, 3)];
            else rf[$urandom_range(0, 7)] = 8'($urandom);
            w = {4'($urandom_range(0, 15)), 5'($urandom)};
            e = model(w);
            exec_inst(w, 1'b0, o);
            checks++;
            if ({o.rdy, o.we, o.br, o.ill} !== {4'b1000, e.we ? 4'b0100 : 4'b0000,
                                               e.br ? 4'b0100 : 4'b0000, e.ill ? 4'b0100 : 4'b0000}) begin
                failures++;
                $display("FAIL rand_pulses inst=%h rdy=%b we=%b br=%b ill=%b required_we/br/ill=%b%b%b",
                         w, o.rdy, o.we, o.br, o.ill, e.we, e.br, e.ill);
            end
            if (e.we) begin
                checks++;
                if ({o.wa, o.wd} !== {e.wa, e.wd}) begin
                    failures++;
                    $display("FAIL rand_write inst=%h addr/data=%h/%h required=%h/%h", w, o.wa, o.wd, e.wa, e.wd);
                end
            end
            checks++;
            if ({o.fz, o.fn} !== {e.fz, e.fn}) begin
                failures++;
                $display("FAIL rand_flags inst=%h z/n=%b required=%b", w, {o.fz, o.fn}, {e.fz, e.fn});
            end
            m_fz = e.fz;
            m_fn = e.fn;
        end
    endtask

    initial begin
        Reset = 1'b1;
        bus.inst_valid = 1'b0;
        bus.inst = '0;
        test_reset();
        test_add();
        test_cmp_branch();
        test_custom();
        test_sub_wrap();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Multi-cycle issue/control sequencer that drives the combinational ALU from its initiator side.
- Accepts one 9-bit instruction per handshake and decodes it into ALU OP and ControlFlags.
- Drives register-file read addresses, captures the ALU result and flags, then performs writeback, flag update or branch resolution.
- Sits between instruction fetch and the register file / ALU pair.

Parameters:
- RC_DEST, 3'd0, destination register for kRC_CUSTOM results.
- NREG_BITS, 3, register-address width (8 registers).

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- inst_valid  in  1  instruction word present.
- inst  in  9  instruction: [8:5] opcode, [4:2] Rd or ControlFlags, [1:0] Rm or branch condition.
- inst_ready  out  1  block can accept an instruction.
- ra_addr  out  3  register-file read address A (Rd).
- rb_addr  out  3  register-file read address B ({1'b0, Rm}).
- ra_data  in  8  register-file read data A (combinational read).
- rb_data  in  8  register-file read data B.
- alu_op  out  4  ALU opcode.
- alu_cf  out  3  ALU ControlFlags.
- alu_a  out  8  ALU InputA.
- alu_b  out  8  ALU InputB.
- alu_out  in  8  ALU result.
- alu_zero  in  1  ALU Zero flag.
- alu_neg  in  1  ALU Negative flag.
- wr_en  out  1  register-file write strobe.
- wr_addr  out  3  write address.
- wr_data  out  8  write data.
- flag_z  out  1  architectural zero flag.
- flag_n  out  1  architectural negative flag.
- branch_taken  out  1  one-cycle pulse when a branch resolves taken.
- illegal  out  1  one-cycle pulse for an undefined opcode.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: state goes to IDLE and the instruction register clears to 0. All of the following are 0: wr_en, wr_addr, wr_data, flag_z, flag_n, branch_taken, illegal, busy, alu_op, alu_cf, alu_a, alu_b. inst_ready is 1.
- Reset mid-operation: the in-flight instruction is discarded, with no write and no flag change.
- FSM states: IDLE -> DECODE -> EXEC -> WB -> IDLE.
- IDLE: inst_ready=1. On inst_valid&&inst_ready, latch inst and go to DECODE. Otherwise stay.
- DECODE:
  - ra_addr=inst[4:2], rb_addr={1'b0,inst[1:0]}.
  - Register ra_data/rb_data into the operand regs.
  - Register alu_op=inst[8:5] and alu_cf=inst[4:2].
- EXEC: alu_a and alu_b hold the operand regs. Capture alu_out, alu_zero and alu_neg into the result regs.
- WB, write ops (kRC_ADD, kRC_SUB, kRC_LSL, kRC_LSR, kRC_TRANSFER, kREG_COPY, kADD, kSUB, kXOR, kAND, kLSL, kLSR):
  - wr_en=1 for exactly one cycle.
  - wr_addr=Rd, wr_data=captured result.
- WB, kRC_CUSTOM: wr_en=1, wr_addr=RC_DEST, wr_data=captured result.
  - ControlFlags codes with no defined constant (3'b010, 3'b111) write whatever the ALU returns; this block does not mask them.
- WB, kCMP: no write. flag_z and flag_n load the captured ALU flags.
- Flags change only on kCMP and on reset. All other ops leave them unchanged.
- WB, kBRANCH: no write, flags unchanged.
  - Condition inst[1:0]: 00 always, 01 flag_z, 10 flag_n, 11 !flag_z.
  - branch_taken=1 for one cycle if the condition is true.
  - The condition uses flag values held before WB.
- WB, undefined opcode (no op_mne member): treated as NOP. No write, no flag change; illegal=1 for one cycle.
- Latency and throughput:
  - Accept edge = cycle 0; wr_en, branch_taken and illegal are asserted in cycle 3.
  - inst_ready returns high in cycle 4, so throughput is 1 instruction per 4 cycles.
- inst_valid while busy is ignored; the source must hold the instruction until the handshake completes.
- wr_en, branch_taken and illegal are mutually exclusive and never assert outside WB.
- Arithmetic is 8-bit with wrap-around inside the ALU. This block performs no arithmetic and no width extension beyond Rm zero-extension.

Decomposition:
- Shared definitions package, added alongside op_mne:
  - ctrl_state_t enum (IDLE, DECODE, EXEC, WB).
  - br_cond_t enum (BR_AL, BR_Z, BR_N, BR_NZ).
  - Instruction field position constants.
- One natural sub-module, alu_issue_decode (combinational): maps opcode to writes_reg, writes_flags, is_branch, is_custom and is_illegal.
- FSM and datapath registers remain in alu_issue_ctrl.

Test Plan:
- R2=0x05, R1=0x03, issue kADD Rd=2 Rm=1 -> cycle 3: wr_en=1, wr_addr=2, wr_data=0x08; flags unchanged.
- R3=0x10, R2=0x10, kCMP Rd=3 Rm=2 -> no wr_en, flag_z=1, flag_n=0. Then kBRANCH cond=01 -> branch_taken pulse. Then kBRANCH cond=11 -> no pulse.
- kRC_CUSTOM ControlFlags=3'b110 -> wr_addr=RC_DEST (0), wr_data=0x80.
- R1=0x01, R0=0x02, kSUB Rd=1 Rm=0 -> wr_data=0xFF (wrap). Then kCMP same regs -> flag_n=1, flag_z=0.
- Hold inst_valid high with different words during busy -> only the first word executes. inst_ready low cycles 1-3, high cycle 4.
- Assert Reset during EXEC of kADD -> no wr_en, all outputs 0, inst_ready=1. An undefined opcode issued afterwards -> illegal pulse in cycle 3, no write.
